hamming_rx_ctrl: RTL

Receive-side controller for the Hamming (7,4) link. It frames a one-bit-per-clock serial stream into codewords, sequences an enable-gated SIPO shift register, and double-buffers each completed codeword into a parallel holding register. The held word is offered to the downstream decoder over a valid/ready handshake. Framing errors and overruns are flagged and counted.

---
 rtl/hamming_rx_ctrl_pkg.sv | 15 +
 rtl/hamming_rx_ctrl_sipo.sv | 20 ++
 rtl/hamming_rx_ctrl.sv | 99 +++++++++
 3 files changed

// File: rtl/hamming_rx_ctrl_pkg.sv
// Shared definitions for the Hamming (7,4) receive controller:
// FSM state encoding, line levels and the default frame width.
package hamming_rx_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STOP  = 2'd2
  } rx_state_t;

  localparam logic START_LVL       = 1'b1;
  localparam logic STOP_LVL        = 1'b0;
  localparam int   DEFAULT_FRAME_W = 7;

endpackage

// File: rtl/hamming_rx_ctrl_sipo.sv
// Enable-gated serial-in/parallel-out shift register, MSB arrives first.
module sipo_shift_en #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         SI,
  output logic [W-1:0] PO
);

  always_ff @(posedge clk) begin
    if (rst) begin
      PO <= '0;
    end else if (en) begin
      PO <= {PO[W-2:0], SI};
    end
  end

endmodule

// File: rtl/hamming_rx_ctrl.sv
// Frames the serial codeword stream, double-buffers each good frame into PO
// behind a valid/ready handshake, and flags/counts framing errors and overruns.
module hamming_rx_ctrl
  import hamming_rx_ctrl_pkg::*;
#(
  parameter int FRAME_W   = DEFAULT_FRAME_W,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 SI,
  output logic [FRAME_W-1:0]   PO,
  output logic                 po_valid,
  input  logic                 po_ready,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 overrun,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int               CNT_W    = $clog2(FRAME_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

  rx_state_t          state, state_nxt;
  logic [CNT_W-1:0]   bit_cnt;
  logic [FRAME_W-1:0] shift_q;
  logic               shift_en;
  logic               hold_free;
  logic               load;
  logic               drop_ovr;
  logic               drop_ferr;

  sipo_shift_en #(.W(FRAME_W)) u_sipo (
    .clk (clk),
    .rst (rst),
    .en  (shift_en),
    .SI  (SI),
    .PO  (shift_q)
  );

  // A word being consumed this edge frees the holding register for a new load.
  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    load      = 1'b0;
    drop_ovr  = 1'b0;
    drop_ferr = 1'b0;
    hold_free = !po_valid || po_ready;
    case (state)
      IDLE: begin
        if (SI == START_LVL) state_nxt = SHIFT;
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (bit_cnt == LAST_BIT) state_nxt = STOP;
      end
      STOP: begin
        state_nxt = IDLE;
        if (SI == STOP_LVL) begin
          if (hold_free) load = 1'b1;
          else           drop_ovr = 1'b1;
        end else begin
          drop_ferr = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      PO        <= '0;
      po_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= (state == SHIFT) ? bit_cnt + 1'b1 : '0;
      frame_err <= drop_ferr;
      overrun   <= drop_ovr;
      if (load) begin
        PO       <= shift_q;
        po_valid <= 1'b1;
      end else if (po_valid && po_ready) begin
        po_valid <= 1'b0;
      end
      // Error counter saturates rather than wrapping.
      if ((drop_ferr || drop_ovr) && (err_cnt != '1)) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule
